// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter
// Round-robin arbiter for NREQ requesters. A rotating priority pointer selects
// the winner through a rotate + lowest-set-bit priority encoder. A grant is
// held for at most MAX_HOLD cycles. It is released early when the holder drops
// its request or when en falls. On release the pointer moves past the holder,
// and the next winner is granted on the same edge, so there is no idle bubble.
// All outputs are registered and cleared asynchronously by rst.

module rr_priority_arbiter #(
  parameter int NREQ     = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_r;
  logic [IDW-1:0]  ptr_r;
  logic [3:0]      hcnt_r;
  logic [NREQ-1:0] gnt_r;
  logic [IDW-1:0]  gnt_id_r;
  logic            gnt_valid_r;

  logic            release_s;
  logic [IDW-1:0]  next_ptr_s;
  logic [NREQ-1:0] rot_req_s;
  logic [IDW-1:0]  winner_s;
  logic            any_req_s;

  // Index of the lowest set bit, or 0 when the vector is empty.
  function automatic logic [IDW-1:0] lsb_enc(input logic [NREQ-1:0] v);
    logic [IDW-1:0] idx;
    idx = {IDW{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Release check, effective pointer, and rotated priority search for this edge.
  always_comb begin
    release_s  = 1'b0;
    next_ptr_s = ptr_r;
    rot_req_s  = {NREQ{1'b0}};
    any_req_s  = |req;
    if (state_r == ST_GRANT) begin
      release_s = (req[gnt_id_r] == 1'b0) || (en == 1'b0) ||
                  (hcnt_r == 4'(MAX_HOLD));
    end else begin
      release_s = 1'b0;
    end
    // Requests arriving together with a release compete under the advanced pointer.
    if (release_s) begin
      next_ptr_s = gnt_id_r + {{(IDW-1){1'b0}}, 1'b1};
    end else begin
      next_ptr_s = ptr_r;
    end
    // Bit i of rot_req_s is requester (next_ptr_s + i) mod NREQ.
    for (int i = 0; i < NREQ; i++) begin
      rot_req_s[i] = req[IDW'(i) + next_ptr_s];
    end
    winner_s = lsb_enc(rot_req_s) + next_ptr_s;
  end

  // Grant FSM: issues, holds, rotates and revokes grants. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {IDW{1'b0}};
      hcnt_r      <= 4'd0;
      gnt_r       <= {NREQ{1'b0}};
      gnt_id_r    <= {IDW{1'b0}};
      gnt_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (en && any_req_s) begin
            state_r     <= ST_GRANT;
            hcnt_r      <= 4'd1;
            gnt_r       <= {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
            gnt_id_r    <= winner_s;
            gnt_valid_r <= 1'b1;
          end else begin
            state_r     <= ST_IDLE;
            hcnt_r      <= 4'd0;
            gnt_r       <= {NREQ{1'b0}};
            gnt_id_r    <= {IDW{1'b0}};
            gnt_valid_r <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!release_s) begin
            hcnt_r <= hcnt_r + 4'd1;
          end else begin
            ptr_r <= next_ptr_s;
            if (en && any_req_s) begin
              // Back-to-back grant. A sole requester at MAX_HOLD expiry gets a fresh tenure.
              hcnt_r      <= 4'd1;
              gnt_r       <= {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
              gnt_id_r    <= winner_s;
              gnt_valid_r <= 1'b1;
            end else begin
              state_r     <= ST_IDLE;
              hcnt_r      <= 4'd0;
              gnt_r       <= {NREQ{1'b0}};
              gnt_id_r    <= {IDW{1'b0}};
              gnt_valid_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          ptr_r       <= {IDW{1'b0}};
          hcnt_r      <= 4'd0;
          gnt_r       <= {NREQ{1'b0}};
          gnt_id_r    <= {IDW{1'b0}};
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign gnt_id    = gnt_id_r;
  assign gnt_valid = gnt_valid_r;

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Shares one downstream resource among 8 requesters using rotating (round-robin) priority built on an 8-to-3 priority encoder.
- Grants exactly one requester at a time and holds the grant for a bounded burst.
- Reports the granted requester as a one-hot vector plus an encoded index, for driving the resource-side mux.
- Sits between requester agents and the shared datapath. Replaces the fixed-priority encoder where starvation is unacceptable.

Parameters:
- NREQ, 8, number of requesters; the design is exercised only at 8.
- IDW, 3, width of the encoded grant index (log2 NREQ).
- MAX_HOLD, 4, maximum consecutive cycles per grant tenure; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbiter enable. When 0, no new grant is issued and any current grant is revoked.
- req  input  NREQ  request vector; bit i is requester i.
- gnt  output  NREQ  one-hot grant, registered.
- gnt_id  output  IDW  encoded index of the granted requester, registered.
- gnt_valid  output  1  high when gnt is non-zero, registered.

Behaviour:
- Reset (asynchronous, immediate):
  - gnt=0, gnt_id=0, gnt_valid=0.
  - Priority pointer ptr=0, hold counter hcnt=0, state=IDLE.
  - Reset mid-grant drops gnt in the same instant, with no clock edge needed.
- Priority search: scan index ptr, ptr+1, …, wrapping modulo 8. The first index with req=1 wins, so ptr has the highest priority.
- State IDLE:
  - If en=1 and req≠0: at the next edge load gnt/gnt_id for the winner, set gnt_valid=1, hcnt=1, go to GRANT.
  - Otherwise all outputs stay 0.
- State GRANT: at each edge, evaluate the release condition: req[gnt_id]=0, or en=0, or hcnt=MAX_HOLD.
  - No release: hold the grant and increment hcnt.
  - Release: set ptr=(gnt_id+1) mod 8, then re-arbitrate in the same edge using the new ptr.
    - If en=1 and any req bit is set, issue the new grant directly, with no idle bubble; hcnt=1, stay in GRANT.
    - Otherwise clear the outputs and go to IDLE.
- Latency:
  - req rising before edge k gives gnt at edge k.
  - A holder dropping req before edge k loses gnt at edge k.
- MAX_HOLD expiry with the holder still requesting:
  - The holder moves to lowest priority.
  - If it is the sole requester, it is re-granted with a fresh tenure (hcnt=1). gnt stays continuously high, and gnt_id is unchanged.
- en=0 while in GRANT:
  - The grant is revoked at the next edge and ptr advances past the holder.
  - Outputs are 0 while en=0.
- Wrap-around: gnt_id=7 released gives ptr=0.
- Simultaneous events: requests arriving in the same cycle as a release compete under the updated ptr. A requester present at release always beats one that is lower in rotation order.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid equals |gnt.
  - gnt_id matches the position of the gnt bit when gnt_valid=1, and is 0 otherwise.
  - hcnt never exceeds MAX_HOLD.
- Fairness: with continuous requests from all 8 requesters, each is granted within 7×MAX_HOLD cycles of its previous tenure ending.

Test Plan:
- Reset, then en=1, req=8'b0100_0001 → next edge gnt=8'b0000_0001, gnt_id=0. After 4 cycles (MAX_HOLD), gnt=8'b0100_0000, gnt_id=6, with no gap cycle.
- Continuing with req held at 8'b0100_0001 → id6 for 4 cycles, then wrap to id0 (ptr=7 scans 7→0). The sequence 0,6,0,6 repeats.
- req=8'b0000_1000 only, held for 10 cycles → gnt_id=3 continuously, gnt_valid never drops, tenure restarts every 4 cycles.
- Holder id2 drops req after 2 cycles while req[5]=1 → edge after the drop: gnt=8'b0010_0000, gnt_id=5.
- en 1→0 during a grant to id4 with req=8'hFF → next edge gnt=0, gnt_valid=0. When en returns to 1 → gnt_id=5.
- Assert rst asynchronously mid-grant (between edges) → gnt=0, gnt_id=0, gnt_valid=0 immediately. After release with req=8'hFF → gnt_id=0.
- Random req/en stimulus for 500 cycles with checker → one-hot, index-consistency, MAX_HOLD and fairness invariants all hold.
